pipe_perf_monitor: RTL
======================

Name: pipe_perf_monitor

Overview:
- Cycle-accurate performance monitor that sits directly downstream of the pipelined CPU core.
- Taps hazard, control, IF/ID flush and PC signals and counts run cycles, load-use stalls, flushes and PC-hold cycles.
- Stops automatically after a cycle budget and offers a req/ack snapshot port, so benches and debug logic read consistent statistics instead of probing hierarchy.

Parameters:
- CNT_W, 32, width of every counter and snapshot field.
- MAX_CYCLES, 500, run-cycle budget; 0 means unlimited (never enters DONE).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  CPU start level; high enables counting.
- stall_i  in  1  hazard-unit mux-select (stall request).
- jump_i  in  1  control-unit jump decode.
- branch_i  in  1  control-unit branch decode.
- flush_i  in  1  IF/ID flush.
- pc_i  in  32  current PC value.
- clear_i  in  1  synchronous counter clear.
- snap_req_i  in  1  snapshot request.
- snap_ack_i  in  1  snapshot consumed.
- state_o  out  2  FSM state (IDLE=0, RUN=1, DONE=2).
- done_o  out  1  high while in DONE.
- cycle_cnt_o  out  CNT_W  run cycles.
- stall_cnt_o  out  CNT_W  qualified stalls.
- flush_cnt_o  out  CNT_W  flushes.
- hold_cnt_o  out  CNT_W  cycles where PC equals the previous PC.
- snap_valid_o  out  1  snapshot registers hold unconsumed data.
- snap_cycle_o / snap_stall_o / snap_flush_o  out  CNT_W each  captured counts.
- snap_pc_o  out  32  captured pc_i.

Behaviour:
- Reset (rst_i=1 at an edge):
  - State goes to IDLE.
  - All counters, snapshot fields, prev_pc and snap_valid_o go to 0.
  - rst_i has highest priority.
- Update priority: rst_i > clear_i > FSM/counting. Snapshot logic runs in parallel with clear_i.
- IDLE:
  - Counters hold their values.
  - An edge with start_i=1 moves to RUN. Nothing is counted on that edge; prev_pc<=pc_i.
- RUN, on each edge:
  - cycle_cnt += 1.
  - stall_cnt += 1 iff stall_i && !jump_i && !branch_i.
  - flush_cnt += 1 iff flush_i.
  - hold_cnt += 1 iff pc_i == prev_pc.
  - prev_pc <= pc_i.
- RUN exits:
  - start_i=0 at an edge → IDLE, counts retained, no count that edge.
  - If MAX_CYCLES != 0 and cycle_cnt == MAX_CYCLES-1 at an edge, that edge's increments apply, cycle_cnt becomes MAX_CYCLES, and state becomes DONE.
- DONE:
  - Counters frozen and done_o=1 (registered, asserted the cycle after the final count).
  - start_i is ignored.
  - Only clear_i or rst_i leaves DONE.
- clear_i=1 at an edge:
  - All four counters and prev_pc go to 0; state goes to IDLE.
  - Snapshot fields and snap_valid_o are untouched.
- Saturation: each counter saturates at all-ones and never wraps. This only matters when MAX_CYCLES=0.
- Snapshot capture:
  - snap_req_i=1 at an edge with snap_valid_o=0 captures the counter values as updated by that same edge, plus pc_i.
  - snap_valid_o=1 from the next cycle.
- Snapshot hold and release:
  - While snap_valid_o=1, fields are stable and snap_req_i is ignored.
  - snap_ack_i=1 with snap_valid_o=1 clears snap_valid_o at that edge. A simultaneous snap_req_i is ignored and must be re-issued.
  - snap_ack_i with snap_valid_o=0 has no effect.
- Capture on the clear_i edge takes the pre-clear counter values; clear wins for the live counters.
- Latency: every output is registered; no combinational input→output path.

Decomposition:
- Shared package `perf_pkg`:
  - state enum (IDLE/RUN/DONE, 2 bits).
  - CNT_W default.
  - `stall_qualify` function (stall && !jump && !branch) for reuse by bench scoreboards.
- Sub-module `sat_counter` (CNT_W, inc, clr, en): instantiated four times; top holds the FSM, prev_pc and snapshot regs.

Test Plan:
- Reset then start_i=1 for 10 cycles, stall_i=1 on 3 cycles (one with branch_i=1), flush_i=1 on 2 → cycle=10, stall=2, flush=2.
- MAX_CYCLES=5, start_i held high → cycle_cnt stops at 5, state_o=2 and done_o=1 the next cycle; further stall/flush pulses are not counted.
- pc_i sequence 0,4,4,4,8 in RUN → hold_cnt=2.
- snap_req_i at run cycle 4 → snap_valid_o=1 next cycle with snap_cycle_o=4; second req ignored; ack clears it; req+ack on the same edge leaves valid=0.
- clear_i in DONE → counters 0, state IDLE, snapshot retained; rst_i mid-RUN → all outputs 0 the next cycle.
- MAX_CYCLES=0, CNT_W=4, 20 run cycles → cycle_cnt saturates at 15 and state stays RUN.

Source files
------------

// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : perf_pkg
// Brief   : Shared types and helpers for the pipeline performance monitor.
// Revision: 1.0
// ============================================================================
package perf_pkg;

    localparam int c_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } perf_state_t;

    // A stall caused by a taken jump/branch is a control redirect, not a load-use stall.
    function automatic logic stall_qualify(input logic stall, input logic jump,
                                           input logic branch);
        return stall & ~jump & ~branch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Saturating event counter with synchronous clear.
// Revision: 1.0
// ============================================================================
module sat_counter
    import perf_pkg::*;
#(
    parameter int CNT_W = c_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module  : pipe_perf_monitor
// Brief   : Counts run cycles, load-use stalls, flushes and PC holds of the
//           core, with a cycle budget and a req/ack snapshot port.
// Revision: 1.0
// ============================================================================
module pipe_perf_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W      = c_CNT_W,
    parameter int MAX_CYCLES = 500
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic [31:0]      pc_i,
    input  logic             clear_i,
    input  logic             snap_req_i,
    input  logic             snap_ack_i,
    output logic [1:0]       state_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] hold_cnt_o,
    output logic             snap_valid_o,
    output logic [CNT_W-1:0] snap_cycle_o,
    output logic [CNT_W-1:0] snap_stall_o,
    output logic [CNT_W-1:0] snap_flush_o,
    output logic [31:0]      snap_pc_o
);

    perf_state_t      r_state;
    perf_state_t      w_state_nxt;
    logic [31:0]      r_prev_pc;
    logic             w_count_en;
    logic             w_at_limit;
    logic             w_stall_inc;
    logic             w_hold_inc;
    logic [CNT_W-1:0] w_snap_cycle;
    logic [CNT_W-1:0] w_snap_stall;
    logic [CNT_W-1:0] w_snap_flush;

    function automatic logic [CNT_W-1:0] sat_bump(input logic [CNT_W-1:0] v,
                                                  input logic inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

    assign w_count_en  = (r_state == ST_RUN) && start_i;
    assign w_at_limit  = (MAX_CYCLES != 0) && (cycle_cnt_o == CNT_W'(MAX_CYCLES - 1));
    assign w_stall_inc = stall_qualify(stall_i, jump_i, branch_i);
    assign w_hold_inc  = (pc_i == r_prev_pc);
    assign state_o     = r_state;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start_i) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!start_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_at_limit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (clear_i) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            done_o  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            done_o  <= (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_prev_pc <= '0;
        end else if (((r_state == ST_IDLE) && start_i) || w_count_en) begin
            r_prev_pc <= pc_i;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk(clk_i), .rst(rst_i), .clr(clear_i), .en(w_count_en),
        .inc(1'b1), .cnt(cycle_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk_i), .rst(rst_i), .clr(clear_i), .en(w_count_en),
        .inc(w_stall_inc), .cnt(stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk_i), .rst(rst_i), .clr(clear_i), .en(w_count_en),
        .inc(flush_i), .cnt(flush_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk(clk_i), .rst(rst_i), .clr(clear_i), .en(w_count_en),
        .inc(w_hold_inc), .cnt(hold_cnt_o)
    );

    // Snapshot sees post-edge counts, except on a clear edge where it keeps the pre-clear totals.
    always_comb begin
        w_snap_cycle = cycle_cnt_o;
        w_snap_stall = stall_cnt_o;
        w_snap_flush = flush_cnt_o;
        if (!clear_i) begin
            w_snap_cycle = sat_bump(cycle_cnt_o, w_count_en);
            w_snap_stall = sat_bump(stall_cnt_o, w_count_en && w_stall_inc);
            w_snap_flush = sat_bump(flush_cnt_o, w_count_en && flush_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_valid_o <= 1'b0;
            snap_cycle_o <= '0;
            snap_stall_o <= '0;
            snap_flush_o <= '0;
            snap_pc_o    <= '0;
        end else if (snap_valid_o) begin
            if (snap_ack_i) begin
                snap_valid_o <= 1'b0;
            end
        end else if (snap_req_i) begin
            snap_valid_o <= 1'b1;
            snap_cycle_o <= w_snap_cycle;
            snap_stall_o <= w_snap_stall;
            snap_flush_o <= w_snap_flush;
            snap_pc_o    <= pc_i;
        end
    end

endmodule
`default_nettype wire
